// File: rtl/sap_ctrl_seq_if.sv
// Control bundle between the SAP sequencer and its datapath.
// The master drives strobes and stage, and the slave (datapath) drives the
// instruction word and the registered flags.
interface sap_ctrl_seq_if;
    localparam int unsigned WORD_W  = 8;
    localparam int unsigned STAGE_W = 3;

    logic [WORD_W-1:0]  ir_in;
    logic               flag_c;
    logic               flag_z;

    logic               pc_en;
    logic               pc_inc;
    logic               pc_load;
    logic               mar_load;
    logic               mem_en;
    logic               mem_load;
    logic               ir_load;
    logic               ir_en;
    logic               a_load;
    logic               a_en;
    logic               b_load;
    logic               alu_en;
    logic               alu_sub;
    logic               flags_load;
    logic               out_load;
    logic               hlt;
    logic [STAGE_W-1:0] stage;

    modport master (
        input  ir_in, flag_c, flag_z,
        output pc_en, pc_inc, pc_load, mar_load, mem_en, mem_load,
               ir_load, ir_en, a_load, a_en, b_load, alu_en, alu_sub,
               flags_load, out_load, hlt, stage
    );

    modport slave (
        output ir_in, flag_c, flag_z,
        input  pc_en, pc_inc, pc_load, mar_load, mem_en, mem_load,
               ir_load, ir_en, a_load, a_en, b_load, alu_en, alu_sub,
               flags_load, out_load, hlt, stage
    );
endinterface

// File: rtl/sap_ctrl_seq.sv
// Fetch/execute control sequencer for the SAP-style 8-bit CPU.
// Optional macro SAP_CTRL_SINGLE_STEP_EN adds a 'step' input that gates
// both state advance and strobes, so each micro-operation fires once per pulse.
module sap_ctrl_seq (
    input  logic           clk,
    input  logic           rst,
`ifdef SAP_CTRL_SINGLE_STEP_EN
    input  logic           step,
`endif
    sap_ctrl_seq_if.master bus
);
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_STA = 4'h3;
    localparam logic [OP_W-1:0] OP_LDI = 4'h4;
    localparam logic [OP_W-1:0] OP_JMP = 4'h5;
    localparam logic [OP_W-1:0] OP_JC  = 4'h6;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_F0   = 3'd0,
        ST_F1   = 3'd1,
        ST_E0   = 3'd2,
        ST_E1   = 3'd3,
        ST_E2   = 3'd4,
        ST_HALT = 3'd7
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] opcode_c;
    logic            adv_c;
    logic            gate_c;
    logic            unused_operand_c;

    logic pc_en_c, pc_inc_c, pc_load_c, mar_load_c, mem_en_c, mem_load_c;
    logic ir_load_c, ir_en_c, a_load_c, a_en_c, b_load_c, alu_en_c;
    logic alu_sub_c, flags_load_c, out_load_c;

`ifdef SAP_CTRL_SINGLE_STEP_EN
    assign adv_c = step;
`else
    assign adv_c = 1'b1;
`endif

    assign opcode_c         = bus.ir_in[7:4];
    assign unused_operand_c = ^bus.ir_in[3:0];
    assign gate_c           = ~rst & adv_c;

    // State register: synchronous reset, advance only when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_F0;
        end else if (adv_c) begin
            state_q <= state_d;
        end
    end

    // Next-state decode: instruction length set by opcode
    always_comb begin
        state_d = ST_F0;
        case (state_q)
            ST_F0: state_d = ST_F1;
            ST_F1: state_d = ST_E0;
            ST_E0: begin
                if (opcode_c == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (opcode_c == OP_LDA || opcode_c == OP_ADD ||
                             opcode_c == OP_SUB || opcode_c == OP_STA) begin
                    state_d = ST_E1;
                end else begin
                    state_d = ST_F0;
                end
            end
            ST_E1: begin
                if (opcode_c == OP_ADD || opcode_c == OP_SUB) begin
                    state_d = ST_E2;
                end else begin
                    state_d = ST_F0;
                end
            end
            ST_E2:   state_d = ST_F0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_F0;
        endcase
    end

    // Micro-operation decode from state, opcode and flags
    always_comb begin
        pc_en_c      = 1'b0;
        pc_inc_c     = 1'b0;
        pc_load_c    = 1'b0;
        mar_load_c   = 1'b0;
        mem_en_c     = 1'b0;
        mem_load_c   = 1'b0;
        ir_load_c    = 1'b0;
        ir_en_c      = 1'b0;
        a_load_c     = 1'b0;
        a_en_c       = 1'b0;
        b_load_c     = 1'b0;
        alu_en_c     = 1'b0;
        alu_sub_c    = 1'b0;
        flags_load_c = 1'b0;
        out_load_c   = 1'b0;
        case (state_q)
            ST_F0: begin
                pc_en_c    = 1'b1;
                mar_load_c = 1'b1;
            end
            ST_F1: begin
                mem_en_c  = 1'b1;
                ir_load_c = 1'b1;
                pc_inc_c  = 1'b1;
            end
            ST_E0: begin
                case (opcode_c)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_en_c    = 1'b1;
                        mar_load_c = 1'b1;
                    end
                    OP_LDI: begin
                        ir_en_c  = 1'b1;
                        a_load_c = 1'b1;
                    end
                    OP_JMP: begin
                        ir_en_c   = 1'b1;
                        pc_load_c = 1'b1;
                    end
                    OP_JC: begin
                        ir_en_c   = bus.flag_c;
                        pc_load_c = bus.flag_c;
                    end
                    OP_JZ: begin
                        ir_en_c   = bus.flag_z;
                        pc_load_c = bus.flag_z;
                    end
                    OP_OUT: begin
                        a_en_c     = 1'b1;
                        out_load_c = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E1: begin
                case (opcode_c)
                    OP_LDA: begin
                        mem_en_c = 1'b1;
                        a_load_c = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        mem_en_c = 1'b1;
                        b_load_c = 1'b1;
                    end
                    OP_STA: begin
                        a_en_c     = 1'b1;
                        mem_load_c = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_E2: begin
                if (opcode_c == OP_ADD || opcode_c == OP_SUB) begin
                    alu_en_c     = 1'b1;
                    a_load_c     = 1'b1;
                    flags_load_c = 1'b1;
                    alu_sub_c    = (opcode_c == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    // Strobes are suppressed during reset and while not stepping
    assign bus.pc_en      = pc_en_c      & gate_c;
    assign bus.pc_inc     = pc_inc_c     & gate_c;
    assign bus.pc_load    = pc_load_c    & gate_c;
    assign bus.mar_load   = mar_load_c   & gate_c;
    assign bus.mem_en     = mem_en_c     & gate_c;
    assign bus.mem_load   = mem_load_c   & gate_c;
    assign bus.ir_load    = ir_load_c    & gate_c;
    assign bus.ir_en      = ir_en_c      & gate_c;
    assign bus.a_load     = a_load_c     & gate_c;
    assign bus.a_en       = a_en_c       & gate_c;
    assign bus.b_load     = b_load_c     & gate_c;
    assign bus.alu_en     = alu_en_c     & gate_c;
    assign bus.alu_sub    = alu_sub_c    & gate_c;
    assign bus.flags_load = flags_load_c & gate_c;
    assign bus.out_load   = out_load_c   & gate_c;
    assign bus.hlt        = (state_q == ST_HALT) & ~rst;
    assign bus.stage      = state_q;
endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
- Control sequencer for the SAP-style 8-bit CPU.
- Consumes the instruction register output and the ALU flags, and steps a fetch/execute state machine.
- Drives every load, enable and increment strobe on the shared 8-bit bus.
- The instruction register is written at the end of the fetch phase. This block reads that value and issues the micro-operations for the instruction.

Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ir_in  in  8  instruction register contents; opcode = ir_in[7:4], operand/address = ir_in[3:0]
- flag_c  in  1  registered ALU carry flag
- flag_z  in  1  registered ALU zero flag
- pc_en  out  1  PC drives bus
- pc_inc  out  1  PC increments
- pc_load  out  1  PC loads from bus
- mar_load  out  1  MAR loads from bus
- mem_en  out  1  RAM drives bus
- mem_load  out  1  RAM writes bus at MAR
- ir_load  out  1  IR write enable
- ir_en  out  1  IR drives ir_in[3:0] onto bus, zero-extended
- a_load / a_en  out  1 each  accumulator load / drive bus
- b_load  out  1  B register load
- alu_en  out  1  ALU result drives bus
- alu_sub  out  1  ALU subtracts (0 = add)
- flags_load  out  1  flag register captures ALU flags
- out_load  out  1  output register load
- hlt  out  1  CPU halted
- stage  out  3  current state encoding, for debug

Behaviour:
- Clocking and reset
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - While rst=1, every strobe output is 0.
  - On the first edge with rst=1, state becomes F0 (stage=0).
  - Reset mid-instruction abandons the instruction; no partial strobes follow.
- States and encoding
  - F0=0, F1=1, E0=2, E1=3, E2=4, HALT=7.
  - Exactly one state per clock.
  - Strobes are combinational from the state, ir_in[7:4], flag_c and flag_z.
  - Downstream registers capture on the next rising edge.
- Fetch phase
  - F0: pc_en, mar_load. Next state F1.
  - F1: mem_en, ir_load, pc_inc. Next state E0.
  - ir_in is valid from E0 onward.
- Execute phase (the last listed step returns to F0; unlisted steps issue no strobes)
  - LDA 0x0: E0 ir_en+mar_load; E1 mem_en+a_load.
  - ADD 0x1: E0 ir_en+mar_load; E1 mem_en+b_load; E2 alu_en+a_load+flags_load.
  - SUB 0x2: same as ADD, plus alu_sub=1 in E2.
  - STA 0x3: E0 ir_en+mar_load; E1 a_en+mem_load.
  - LDI 0x4: E0 ir_en+a_load.
  - JMP 0x5: E0 ir_en+pc_load.
  - JC 0x6: E0 ir_en+pc_load if flag_c=1, otherwise no strobes. One cycle either way.
  - JZ 0x7: same as JC, using flag_z.
  - OUT 0xE: E0 a_en+out_load.
  - HLT 0xF: E0 no strobes; next state HALT.
  - 0x8–0xD: NOP. E0 issues no strobes, then returns to F0.
- Instruction lengths
  - Total clocks: 2 (fetch) + 1, 2 or 3 (execute).
  - LDA 4, ADD/SUB 5, STA 4, all others 3.
- HALT state
  - hlt=1, all other strobes 0.
  - Stays in HALT until rst.
  - hlt is 0 in every other state.
- Bus and jump rules
  - At most one bus driver (pc_en, mem_en, ir_en, a_en, alu_en) is asserted in any cycle.
  - Conditional jump flags are sampled combinationally in E0 only.

Optional Feature:
- Macro: SAP_CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit) after rst.
  - State advances only on edges where step=1.
  - All strobes are gated with step, so each micro-operation fires exactly once per step pulse.
  - stage holds while step=0.
  - HALT still ignores step.
  - rst overrides step.
- When undefined:
  - No step port; the sequencer advances every clock.

Test Plan:
- Reset then run:
  - Stimulus: rst high for 2 clocks, then low; ir_in=0x4A.
  - Required: stage 0,1,2,0; E0 asserts ir_en and a_load only; F1 asserts ir_load and pc_inc.
- ADD:
  - Stimulus: ir_in=0x1F.
  - Required: 5-cycle sequence; E2 has alu_en=1, a_load=1, flags_load=1, alu_sub=0.
  - Repeat with ir_in=0x2F: identical sequence except alu_sub=1 in E2.
- Conditional jumps:
  - Stimulus: ir_in=0x63 with flag_c=0, then again with flag_c=1.
  - Required: first pass pc_load=0 in E0; second pass pc_load=1 and ir_en=1. Both return to F0 after 3 cycles.
  - Repeat with JZ 0x75 and flag_z.
- Halt:
  - Stimulus: ir_in=0xF0, then 10 more clocks.
  - Required: hlt=1 and stage=7 held, all other strobes 0. A rst pulse returns stage to 0 and hlt to 0.
- Reset mid-instruction and bus exclusivity:
  - Stimulus: assert rst during E1 of STA 0x3C.
  - Required: no mem_load on that edge or after; stage=0.
  - Assertion across a random opcode stream: at most one bus driver high per cycle.
- Single-step (with SAP_CTRL_SINGLE_STEP_EN):
  - Stimulus: step low for 5 clocks.
  - Required: stage frozen and strobes 0; each one-cycle step pulse advances exactly one state.
